// File: rtl/jam_job_controller.sv
// Host-side sequencer: loads an 8x8 cost table, runs the assignment engine, reports results.
// Optional macro JAM_TABLE_KEEP_EN keeps the loaded table valid across runs (reload only after RST).
module jam_job_controller #(
   parameter int COST_W     = 7,
   parameter int TMO_CYCLES = 524288,
   parameter int ARM_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ld_valid,
   input  logic [COST_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [9:0]        res_min,
   output logic [3:0]        res_cnt,
   output logic              err_timeout,
   output logic              jam_rst,
   input  logic [2:0]        jam_W,
   input  logic [2:0]        jam_J,
   output logic [COST_W-1:0] jam_cost,
   input  logic [9:0]        jam_min,
   input  logic [3:0]        jam_cnt,
   input  logic              jam_valid
);

   localparam int               CNT_W    = 20;
   localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_RUN     = 2'd2,
      S_CAPTURE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [5:0]        ld_ptr_q, ld_ptr_d;
   logic              table_full_q, table_full_d;
   logic [9:0]        res_min_q, res_min_d;
   logic [3:0]        res_cnt_q, res_cnt_d;
   logic              err_timeout_q, err_timeout_d;
   logic [COST_W-1:0] cost_tbl_q [64];
   logic [COST_W-1:0] cost_tbl_d [64];

   logic ld_fire;
   logic start_ok;
   logic arm_last;
   logic run_tmo;

   assign ld_fire  = ld_valid & ld_ready;
   assign start_ok = (state_q == S_IDLE) & start & table_full_q;
   assign arm_last = (state_q == S_ARM) & (cyc_q == ARM_LAST);
   assign run_tmo  = (state_q == S_RUN) & (cyc_q == TMO_LAST);

   // The engine samples Cost in the same cycle it drives W/J, so this read must stay combinational.
   assign jam_cost    = cost_tbl_q[{jam_W, jam_J}];
   assign res_min     = res_min_q;
   assign res_cnt     = res_cnt_q;
   assign err_timeout = err_timeout_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            if (arm_last) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (jam_valid || run_tmo) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      ld_ready = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      jam_rst  = 1'b1;
      case (state_q)
         S_IDLE: begin
            busy     = 1'b0;
            ld_ready = ~table_full_q;
         end
         S_RUN: begin
            jam_rst = 1'b0;
         end
         S_CAPTURE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      cyc_d         = '0;
      ld_ptr_d      = ld_ptr_q;
      table_full_d  = table_full_q;
      res_min_d     = res_min_q;
      res_cnt_d     = res_cnt_q;
      err_timeout_d = err_timeout_q;

      // The 64th write wraps the pointer back to 0 and marks the table usable.
      if (ld_fire) begin
         ld_ptr_d = ld_ptr_q + 6'd1;
         if (ld_ptr_q == 6'd63) begin
            table_full_d = 1'b1;
         end
      end

      if (start_ok) begin
         err_timeout_d = 1'b0;
      end

      case (state_q)
         S_ARM: begin
            cyc_d = arm_last ? '0 : cyc_q + CNT_W'(1);
         end
         S_RUN: begin
            cyc_d = cyc_q + CNT_W'(1);
            // A result arriving on the timeout cycle still counts as a normal completion.
            if (jam_valid) begin
               res_min_d = jam_min;
               res_cnt_d = jam_cnt;
            end else if (run_tmo) begin
               res_min_d     = 10'd1023;
               res_cnt_d     = 4'd0;
               err_timeout_d = 1'b1;
            end
         end
`ifdef JAM_TABLE_KEEP_EN
         S_CAPTURE: begin
            table_full_d = table_full_q;
         end
`else
         S_CAPTURE: begin
            table_full_d = 1'b0;
         end
`endif
         default: begin
         end
      endcase
   end

   always_comb begin
      for (int i = 0; i < 64; i++) begin
         cost_tbl_d[i] = (ld_fire && (ld_ptr_q == 6'(i))) ? ld_data : cost_tbl_q[i];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cyc_q         <= '0;
         ld_ptr_q      <= '0;
         table_full_q  <= 1'b0;
         res_min_q     <= '0;
         res_cnt_q     <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         cyc_q         <= cyc_d;
         ld_ptr_q      <= ld_ptr_d;
         table_full_q  <= table_full_d;
         res_min_q     <= res_min_d;
         res_cnt_q     <= res_cnt_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 64; i++) begin
            cost_tbl_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 64; i++) begin
            cost_tbl_q[i] <= cost_tbl_d[i];
         end
      end
   end

endmodule

// File: tb/tb_jam_job_controller.sv
// Directed bench for jam_job_controller: the bench plays host and engine, results checked via a scoreboard.
// Build with or without JAM_TABLE_KEEP_EN; the table-reuse expectations follow the macro.
module tb_jam_job_controller;

   localparam int COST_W = 7;
   localparam int TMO    = 100;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              ld_valid = 1'b0;
   logic [COST_W-1:0] ld_data = '0;
   logic              ld_ready;
   logic              start = 1'b0;
   logic              busy;
   logic              done;
   logic [9:0]        res_min;
   logic [3:0]        res_cnt;
   logic              err_timeout;
   logic              jam_rst;
   logic [2:0]        jam_W = '0;
   logic [2:0]        jam_J = '0;
   logic [COST_W-1:0] jam_cost;
   logic [9:0]        jam_min = '0;
   logic [3:0]        jam_cnt = '0;
   logic              jam_valid = 1'b0;

   jam_job_controller #(
      .COST_W     (COST_W),
      .TMO_CYCLES (TMO),
      .ARM_CYCLES (2)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .res_min     (res_min),
      .res_cnt     (res_cnt),
      .err_timeout (err_timeout),
      .jam_rst     (jam_rst),
      .jam_W       (jam_W),
      .jam_J       (jam_J),
      .jam_cost    (jam_cost),
      .jam_min     (jam_min),
      .jam_cnt     (jam_cnt),
      .jam_valid   (jam_valid)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [9:0] mn;
      logic [3:0] cnt;
      logic       err;
   } exp_t;

   exp_t              sb_q[$];
   logic [COST_W-1:0] model [64];
   int                rd_cost [64];
   int                n_checks = 0;
   int                n_pass   = 0;
   int                n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic set_diag();
      for (int i = 0; i < 64; i++) model[i] = ((i / 8) == (i % 8)) ? 7'd1 : 7'd10;
   endtask

   // Optimum is the unique shifted diagonal (cost 2 each), total 16.
   task automatic set_shift();
      for (int i = 0; i < 64; i++) begin
         int w = i / 8;
         int j = i % 8;
         model[i] = (j == ((w + 3) % 8)) ? 7'd2 : 7'(20 + w + j);
      end
   endtask

   task automatic apply_reset();
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
   endtask

   task automatic load_range(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         ld_valid = 1'b1;
         ld_data  = model[i];
         @(negedge CLK);
      end
      ld_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   // Brute-force optimal assignment over the costs the engine actually read.
   function automatic void min_assign(output int mn, output int cnt);
      int p [8];
      int s, k, l, t;
      bit more;
      for (int i = 0; i < 8; i++) p[i] = i;
      mn   = 1 << 30;
      cnt  = 0;
      more = 1'b1;
      while (more) begin
         s = 0;
         for (int i = 0; i < 8; i++) s += rd_cost[i * 8 + p[i]];
         if (s < mn) begin
            mn  = s;
            cnt = 1;
         end else if (s == mn) begin
            cnt++;
         end
         k = 6;
         while (k >= 0 && p[k] > p[k + 1]) k--;
         if (k < 0) begin
            more = 1'b0;
         end else begin
            l = 7;
            while (p[l] < p[k]) l--;
            t = p[k]; p[k] = p[l]; p[l] = t;
            for (int a = k + 1, b = 7; a < b; a++, b--) begin
               t = p[a]; p[a] = p[b]; p[b] = t;
            end
         end
      end
   endfunction

   task automatic wait_run(input string tag);
      int guard = 0;
      while (jam_rst !== 1'b0 && guard < 10) begin
         @(negedge CLK);
         guard++;
      end
      check({tag, "_run_entry"}, 32'(jam_rst), 32'd0);
   endtask

   // Engine model: sweep all 64 Cost lookups, solve, then present Valid for one cycle.
   task automatic engine_run(input string tag, input bit give_valid);
      int mism = 0;
      int mn, cnt;
      wait_run(tag);
      for (int i = 0; i < 64; i++) begin
         jam_W = 3'(i / 8);
         jam_J = 3'(i % 8);
         #1;
         rd_cost[i] = int'(jam_cost);
         if (jam_cost !== model[i]) mism++;
         @(negedge CLK);
      end
      check({tag, "_tbl_readback"}, 32'(mism), 32'd0);
      if (give_valid) begin
         min_assign(mn, cnt);
         jam_min   = 10'(mn);
         jam_cnt   = 4'((cnt > 15) ? 15 : cnt);
         jam_valid = 1'b1;
         @(negedge CLK);
         jam_valid = 1'b0;
      end
   endtask

   task automatic wait_done(input string tag);
      int   guard = 0;
      exp_t e;
      while (done !== 1'b1 && guard < 300) begin
         @(negedge CLK);
         guard++;
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'(sb_q.size()), 32'd1);
         end else begin
            e = sb_q.pop_front();
            check({tag, "_res_min"}, 32'(res_min), 32'(e.mn));
            check({tag, "_res_cnt"}, 32'(res_cnt), 32'(e.cnt));
            check({tag, "_err_timeout"}, 32'(err_timeout), 32'(e.err));
            $display("txn %s: res_min=%0d res_cnt=%0d err_timeout=%0d", tag, res_min, res_cnt, err_timeout);
         end
      end
      @(negedge CLK);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic check_arm(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_arm1_rst"}, 32'(jam_rst), 32'd1);
      @(negedge CLK);
      check({tag, "_arm2_rst"}, 32'(jam_rst), 32'd1);
      @(negedge CLK);
      check({tag, "_run_rst"}, 32'(jam_rst), 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge CLK);
      RST   = 1'b0;
      jam_W = 3'd3;
      jam_J = 3'd5;
      @(negedge CLK);
      check("rst_ld_ready", 32'(ld_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_res_min", 32'(res_min), 32'd0);
      check("rst_res_cnt", 32'(res_cnt), 32'd0);
      check("rst_err", 32'(err_timeout), 32'd0);
      check("rst_jam_rst", 32'(jam_rst), 32'd1);
      check("rst_jam_cost", 32'(jam_cost), 32'd0);

      // Scenario 1: identity-diagonal ones
      set_diag();
      load_range(0, 63);
      check("s1_ld_ready_full", 32'(ld_ready), 32'd0);
      sb_q.push_back('{mn: 10'd8, cnt: 4'd1, err: 1'b0});
      pulse_start();
      check_arm("s1");
      engine_run("s1", 1'b1);
      wait_done("s1");

      // Scenario 6: restart without reloading
`ifdef JAM_TABLE_KEEP_EN
      check("s6_ld_ready_kept", 32'(ld_ready), 32'd0);
      sb_q.push_back('{mn: 10'd8, cnt: 4'd1, err: 1'b0});
      pulse_start();
      check("s6_busy", 32'(busy), 32'd1);
      engine_run("s6", 1'b1);
      wait_done("s6");
`else
      check("s6_ld_ready_empty", 32'(ld_ready), 32'd1);
      pulse_start();
      check("s6_start_ignored", 32'(busy), 32'd0);
      check("s6_jam_rst", 32'(jam_rst), 32'd1);
`endif
      apply_reset();

      // Scenario 2: second optimal assignment via swapped 0/1
      set_diag();
      model[1] = 7'd1;
      model[8] = 7'd1;
      load_range(0, 63);
      sb_q.push_back('{mn: 10'd8, cnt: 4'd2, err: 1'b0});
      pulse_start();
      check_arm("s2");
      engine_run("s2", 1'b1);
      wait_done("s2");
      apply_reset();

      // Scenario 3: partial load, start ignored; start on the 64th write ignored; drop when not ready
      set_shift();
      load_range(0, 39);
      pulse_start();
      check("s3_busy_partial", 32'(busy), 32'd0);
      check("s3_jam_rst_partial", 32'(jam_rst), 32'd1);
      check("s3_ld_ready_partial", 32'(ld_ready), 32'd1);
      load_range(40, 62);
      ld_valid = 1'b1;
      ld_data  = model[63];
      start    = 1'b1;
      @(negedge CLK);
      ld_valid = 1'b0;
      start    = 1'b0;
      check("s3_start_on_last", 32'(busy), 32'd0);
      check("s3_ld_ready_full", 32'(ld_ready), 32'd0);
      ld_valid = 1'b1;
      ld_data  = 7'h55;
      @(negedge CLK);
      ld_valid = 1'b0;

      // Scenario 4: timeout after exactly TMO RUN cycles
      begin
         int run_cycles = 0;
         sb_q.push_back('{mn: 10'd1023, cnt: 4'd0, err: 1'b1});
         pulse_start();
         engine_run("s4", 1'b0);
         run_cycles = 64;
         for (int i = 0; i < 300 && done !== 1'b1; i++) begin
            if (jam_rst === 1'b0) run_cycles++;
            @(negedge CLK);
         end
         check("s4_run_cycles", 32'(run_cycles), 32'(TMO));
         wait_done("s4");
         check("s4_err_sticky", 32'(err_timeout), 32'd1);
      end
`ifndef JAM_TABLE_KEEP_EN
      load_range(0, 63);
`endif
      sb_q.push_back('{mn: 10'd16, cnt: 4'd1, err: 1'b0});
      pulse_start();
      check("s4_err_cleared", 32'(err_timeout), 32'd0);
      engine_run("s4b", 1'b1);
      wait_done("s4b");

      // Scenario 5: asynchronous reset 50 cycles into RUN
`ifndef JAM_TABLE_KEEP_EN
      load_range(0, 63);
`endif
      pulse_start();
      wait_run("s5");
      repeat (50) @(negedge CLK);
      check("s5_in_run", 32'(jam_rst), 32'd0);
      jam_W = 3'd3;
      jam_J = 3'd5;
      RST   = 1'b1;
      #1;
      check("s5_jam_rst", 32'(jam_rst), 32'd1);
      check("s5_busy", 32'(busy), 32'd0);
      check("s5_ld_ready", 32'(ld_ready), 32'd1);
      check("s5_res_min", 32'(res_min), 32'd0);
      check("s5_jam_cost", 32'(jam_cost), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      pulse_start();
      check("s5_start_ignored", 32'(busy), 32'd0);
      @(negedge CLK);
      check("s5_no_done", 32'(done), 32'd0);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/jam_job_controller.md
Name: jam_job_controller

Overview:
Host-side sequencer for the job-assignment engine.
- Accepts an 8x8 cost matrix from a host stream and stores it in a register table.
- Holds the engine in reset while loading, then releases it and serves its combinational Cost lookups from the table.
- Waits for the engine's Valid, captures MinCost and MatchCount, and reports them to the host with a timeout guard.

Parameters:
COST_W, 7, bit width of one cost entry (matches engine Cost input)
TMO_CYCLES, 524288, maximum RUN cycles before timeout abort (counter width 20)
ARM_CYCLES, 2, cycles jam_rst is held high in ARM before RUN

Ports:
CLK  in  1  clock
RST  in  1  asynchronous, active-high reset
ld_valid  in  1  host cost word valid
ld_data  in  COST_W  cost word, row-major order W*8+J
ld_ready  out  1  controller can accept a cost word
start  in  1  single-cycle request to run the engine on the loaded table
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when results are updated
res_min  out  10  captured minimum cost
res_cnt  out  4  captured match count
err_timeout  out  1  last run aborted by timeout; sticky until next accepted start
jam_rst  out  1  reset to the engine, active-high
jam_W  in  3  engine worker index
jam_J  in  3  engine job index
jam_cost  out  COST_W  table[jam_W][jam_J], combinational
jam_min  in  10  engine MinCost
jam_cnt  in  4  engine MatchCount
jam_valid  in  1  engine Valid

Behaviour:
- Reset values:
  - state IDLE, ld_ptr 0, table_full 0, all table entries 0.
  - ld_ready 1, busy 0, done 0, res_min 0, res_cnt 0, err_timeout 0, jam_rst 1.
  - jam_cost therefore reads 0.
- Reset mid-operation: everything returns to the reset values immediately. The table is invalid and must be fully reloaded.
- States: IDLE, ARM, RUN, CAPTURE.
- Load (IDLE only):
  - ld_ready = (state==IDLE) & ~table_full.
  - Each cycle with ld_valid & ld_ready writes table[ld_ptr] <= ld_data and increments ld_ptr.
  - The write with ld_ptr==63 sets table_full=1 and wraps ld_ptr to 0.
  - ld_valid while ld_ready=0 is dropped with no side effects.
- IDLE -> ARM: on start & table_full. err_timeout clears on the same edge.
  - start while ~table_full is ignored.
  - start in the same cycle as the 64th write is ignored, because table_full is not yet 1.
  - start while busy is ignored.
- ARM: jam_rst=1 for ARM_CYCLES cycles, then -> RUN. The RUN cycle counter clears on entry.
- RUN:
  - jam_rst=0.
  - jam_cost = table[jam_W*8+jam_J] with zero latency, because the engine samples Cost in the same cycle.
  - Counter increments each cycle.
  - jam_valid=1 -> CAPTURE; latch res_min<=jam_min, res_cnt<=jam_cnt.
  - Counter == TMO_CYCLES-1 with jam_valid=0 -> CAPTURE with res_min<=1023, res_cnt<=0, err_timeout<=1.
  - If jam_valid and timeout occur in the same cycle, jam_valid wins: normal capture, no error.
- CAPTURE (one cycle):
  - jam_rst=1, done=1.
  - table_full<=0; ld_ptr is already 0.
  - -> IDLE.
- jam_rst is 1 in all states except RUN.
- ld_data is stored unmodified; no arithmetic is done in this block.

Optional Feature:
JAM_TABLE_KEEP_EN:
- Defined: CAPTURE leaves table_full=1, so start may be reissued without reloading. A reload is possible only after RST.
- Undefined: CAPTURE clears table_full, and every run requires a fresh 64-word load.

Test Plan:
1. Load cost[w][j] = (w==j) ? 1 : 10, then start -> busy=1, jam_rst low after 2 cycles; done pulse with res_min=8, res_cnt=1, err_timeout=0.
2. Load as in scenario 1, additionally set cost[0][1]=cost[1][0]=1 -> res_min=8, res_cnt=2.
3. Load only 40 words, then pulse start -> busy stays 0, jam_rst stays 1, ld_ready stays 1. Load the remaining 24 words -> ld_ready=0.
4. Set TMO_CYCLES=100 and drive engine with jam_valid tied low; start -> done exactly 100 RUN cycles later, res_min=1023, res_cnt=0, err_timeout=1. Next accepted start -> err_timeout=0.
5. Assert RST 50 cycles into RUN -> jam_rst=1, busy=0, ld_ready=1, res_min=0. Issue start without reload -> ignored.
6. Build with JAM_TABLE_KEEP_EN, run scenario 1, then start again with no load -> second done with res_min=8, res_cnt=1. Build without the macro -> second start is ignored.
